// File: rtl/sd_read_arbiter_if.sv
// Requester and SD-controller signals of the block-read arbiter.
// The master side is the arbiter. The slave side is the two streamers plus the controller.
interface sd_read_arbiter_if;
  logic        req0_read;
  logic [31:0] req0_addr;
  logic        req0_accepted;
  logic        req0_byte_available;
  logic [7:0]  req0_dout;

  logic        req1_read;
  logic [31:0] req1_addr;
  logic        req1_accepted;
  logic        req1_byte_available;
  logic [7:0]  req1_dout;

  logic        sd_ready;
  logic        sd_rd;
  logic [31:0] sd_address;
  logic        sd_byte_available;
  logic [7:0]  sd_dout;

  modport master (
    input  req0_read, req0_addr,
    output req0_accepted, req0_byte_available, req0_dout,
    input  req1_read, req1_addr,
    output req1_accepted, req1_byte_available, req1_dout,
    input  sd_ready, sd_byte_available, sd_dout,
    output sd_rd, sd_address
  );

  modport slave (
    output req0_read, req0_addr,
    input  req0_accepted, req0_byte_available, req0_dout,
    output req1_read, req1_addr,
    input  req1_accepted, req1_byte_available, req1_dout,
    output sd_ready, sd_byte_available, sd_dout,
    input  sd_rd, sd_address
  );
endinterface

// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter that shares one SD block-read controller between two streamers.
// It routes each block's byte stream to the owning port and aborts a stalled transfer.
module sd_read_arbiter #(
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter int unsigned ADDR_SHIFT     = 9,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk_in,
  input  logic              reset_in,
  sd_read_arbiter_if.master bus,
  output logic              busy,
  output logic              owner,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DRAIN} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        acc0_q, acc0_d;
  logic        acc1_q, acc1_d;
  logic        tmo_q, tmo_d;
  logic [31:0] addr_q, addr_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [15:0] idle_q, idle_d;

  logic active;
  logic strobe;
  logic win;

  assign active = (state_q == ISSUE) || (state_q == XFER);
  assign strobe = active && bus.sd_byte_available;
  // With both ports requesting, the port that did not win last time goes first.
  assign win    = (bus.req0_read && bus.req1_read) ? ~last_q : bus.req1_read;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    idle_d  = idle_q;
    acc0_d  = 1'b0;
    acc1_d  = 1'b0;
    tmo_d   = 1'b0;

    if (strobe) cnt_d = cnt_q + 10'd1;
    if (active) idle_d = strobe ? '0 : idle_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (bus.sd_ready && (bus.req0_read || bus.req1_read)) begin
          owner_d = win;
          last_d  = win;
          addr_d  = (win ? bus.req1_addr : bus.req0_addr) << ADDR_SHIFT;
          acc0_d  = ~win;
          acc1_d  = win;
          state_d = ISSUE;
        end
      end
      ISSUE: if (!bus.sd_ready) state_d = XFER;
      XFER:  if (32'(cnt_d) >= BLOCK_BYTES) state_d = DRAIN;
      DRAIN: begin
        if (bus.sd_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stall overrides normal progress in both ISSUE and XFER.
    if (active && !strobe && (idle_q == 16'(TIMEOUT_CYCLES - 1))) begin
      tmo_d   = 1'b1;
      state_d = DRAIN;
    end
    if ((state_d == IDLE) || (state_d == DRAIN)) idle_d = '0;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      acc0_q  <= 1'b0;
      acc1_q  <= 1'b0;
      tmo_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      acc0_q  <= acc0_d;
      acc1_q  <= acc1_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      idle_q  <= idle_d;
    end
  end

  assign bus.sd_rd               = (state_q == ISSUE);
  assign bus.sd_address          = addr_q;
  assign bus.req0_accepted       = acc0_q;
  assign bus.req1_accepted       = acc1_q;
  assign bus.req0_byte_available = strobe && !owner_q;
  assign bus.req1_byte_available = strobe && owner_q;
  assign bus.req0_dout           = (active && !owner_q) ? bus.sd_dout : '0;
  assign bus.req1_dout           = (active && owner_q) ? bus.sd_dout : '0;

  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Self-checking bench for sd_read_arbiter: a behavioural SD controller with random byte timing,
// plus a round-robin grant model and per-byte routing checks.
module tb_sd_read_arbiter;
  localparam int unsigned BB  = 512;
  localparam int unsigned SH  = 9;
  localparam int unsigned TMO = 100;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b1;
  logic busy, owner, timeout_err;

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic        m_last = 1'b1;

  sd_read_arbiter_if bus ();

  sd_read_arbiter #(
    .BLOCK_BYTES   (BB),
    .ADDR_SHIFT    (SH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .bus        (bus),
    .busy       (busy),
    .owner      (owner),
    .timeout_err(timeout_err)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    bus.req0_read = 1'b0; bus.req0_addr = '0;
    bus.req1_read = 1'b0; bus.req1_addr = '0;
    bus.sd_ready = 1'b0; bus.sd_byte_available = 1'b0; bus.sd_dout = '0;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk_in);
    reset_in = 1'b1;
    bus.req0_read = 1'b0; bus.req1_read = 1'b0;
    bus.sd_ready = 1'b0; bus.sd_byte_available = 1'b0;
    m_last = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  // Starts from IDLE just after a negedge; leaves the DUT in XFER.
  task automatic do_grant(input logic r0, input logic r1, input logic [31:0] a0,
                          input logic [31:0] a1, output logic w);
    logic [31:0] exp_addr;
    w = (r0 && r1) ? ~m_last : r1;
    m_last = w;
    exp_addr = (w ? a1 : a0) << SH;
    bus.req0_read = r0; bus.req0_addr = a0;
    bus.req1_read = r1; bus.req1_addr = a1;
    bus.sd_ready = 1'b1; bus.sd_byte_available = 1'b0;
    #1;
    n_chk++;
    if ({bus.req1_accepted, bus.req0_accepted, busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL pre_grant_idle: acc1,acc0,busy=%b expected 000",
               {bus.req1_accepted, bus.req0_accepted, busy});
    end
    @(negedge clk_in); #1;
    n_chk++;
    if ({bus.req1_accepted, bus.req0_accepted} !== (w ? 2'b10 : 2'b01) || bus.sd_rd !== 1'b1 ||
        busy !== 1'b1 || owner !== w) begin
      n_fail++;
      $display("FAIL grant: acc=%b sd_rd=%b busy=%b owner=%b expected acc=%b sd_rd=1 busy=1 owner=%b",
               {bus.req1_accepted, bus.req0_accepted}, bus.sd_rd, busy, owner,
               (w ? 2'b10 : 2'b01), w);
    end
    n_chk++;
    if (bus.sd_address !== exp_addr) begin
      n_fail++;
      $display("FAIL grant_address: got %h expected %h", bus.sd_address, exp_addr);
    end
    if (w) bus.req1_read = 1'b0; else bus.req0_read = 1'b0;
    bus.sd_ready = 1'b0;
    @(negedge clk_in); #1;
    n_chk++;
    if ({bus.req1_accepted, bus.req0_accepted} !== 2'b00 || bus.sd_rd !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_to_xfer: acc=%b sd_rd=%b busy=%b expected acc=00 sd_rd=0 busy=1",
               {bus.req1_accepted, bus.req0_accepted}, bus.sd_rd, busy);
    end
  endtask

  task automatic do_bytes(input logic w, input int unsigned n);
    logic [7:0] d;
    logic [7:0] own, oth;
    int unsigned gap;
    for (int unsigned k = 0; k < n; k++) begin
      gap = $urandom_range(2, 0);
      repeat (gap) begin
        @(negedge clk_in);
        bus.sd_byte_available = 1'b0; bus.sd_dout = 8'($urandom);
        #1;
        oth = w ? bus.req0_dout : bus.req1_dout;
        n_chk++;
        if ({bus.req1_byte_available, bus.req0_byte_available} !== 2'b00 || oth !== 8'h00) begin
          n_fail++;
          $display("FAIL gap_cycle: avail=%b other_dout=%h expected avail=00 other_dout=00",
                   {bus.req1_byte_available, bus.req0_byte_available}, oth);
        end
      end
      @(negedge clk_in);
      d = 8'($urandom);
      bus.sd_byte_available = 1'b1; bus.sd_dout = d;
      #1;
      own = w ? bus.req1_dout : bus.req0_dout;
      oth = w ? bus.req0_dout : bus.req1_dout;
      n_chk++;
      if ({bus.req1_byte_available, bus.req0_byte_available} !== (w ? 2'b10 : 2'b01) ||
          own !== d || oth !== 8'h00 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL byte_route[%0d]: avail=%b own=%h other=%h busy=%b expected avail=%b own=%h other=00 busy=1",
                 k, {bus.req1_byte_available, bus.req0_byte_available}, own, oth, busy,
                 (w ? 2'b10 : 2'b01), d);
      end
    end
  endtask

  // Bytes after the block end are dropped; ready returns the DUT to IDLE.
  task automatic do_drain();
    repeat (2) begin
      @(negedge clk_in);
      bus.sd_ready = 1'b0; bus.sd_byte_available = 1'b1; bus.sd_dout = 8'($urandom);
      #1;
      n_chk++;
      if ({bus.req1_byte_available, bus.req0_byte_available, bus.req1_accepted, bus.req0_accepted} !== 4'b0000 ||
          busy !== 1'b1 || bus.sd_rd !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_hold: avail=%b acc=%b busy=%b sd_rd=%b expected avail=00 acc=00 busy=1 sd_rd=0",
                 {bus.req1_byte_available, bus.req0_byte_available},
                 {bus.req1_accepted, bus.req0_accepted}, busy, bus.sd_rd);
      end
    end
    @(negedge clk_in);
    bus.sd_ready = 1'b1; bus.sd_byte_available = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_wait: busy=%b expected 1", busy);
    end
    @(negedge clk_in); #1;
    n_chk++;
    if (busy !== 1'b0 || bus.sd_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_exit: busy=%b sd_rd=%b expected busy=0 sd_rd=0", busy, bus.sd_rd);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_in);
    reset_in = 1'b1;
    #1;
    n_chk++;
    if ({bus.sd_rd, bus.req0_accepted, bus.req1_accepted, busy, owner, timeout_err} !== 6'b000000 ||
        bus.sd_address !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: rd,acc0,acc1,busy,owner,tmo=%b addr=%h expected all 0",
               {bus.sd_rd, bus.req0_accepted, bus.req1_accepted, busy, owner, timeout_err}, bus.sd_address);
    end
    @(negedge clk_in);
    reset_in = 1'b0; bus.sd_ready = 1'b1;
    @(negedge clk_in); #1;
    n_chk++;
    if ({bus.sd_rd, busy, owner} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle_no_req: rd,busy,owner=%b expected 000", {bus.sd_rd, busy, owner});
    end
  endtask

  task automatic test_single();
    logic w;
    apply_reset();
    do_grant(1'b1, 1'b0, 32'd4200000, 32'h0, w);
    do_bytes(w, BB);
    do_drain();
  endtask

  task automatic test_simultaneous();
    logic w;
    logic [31:0] a0, a1;
    apply_reset();
    a0 = $urandom; a1 = $urandom;
    do_grant(1'b1, 1'b1, a0, a1, w);
    do_bytes(w, BB);
    do_drain();
    do_grant(1'b0, 1'b1, a0, a1, w);
    do_bytes(w, BB);
    do_drain();
  endtask

  task automatic test_fairness();
    logic w;
    apply_reset();
    for (int unsigned b = 0; b < 4; b++) begin
      do_grant(1'b1, 1'b1, $urandom, $urandom, w);
      do_bytes(w, BB);
      do_drain();
    end
    bus.req0_read = 1'b0; bus.req1_read = 1'b0;
  endtask

  task automatic test_timeout();
    logic w;
    int unsigned seen;
    apply_reset();
    do_grant(1'b1, 1'b0, $urandom, 32'h0, w);
    do_bytes(w, 10);
    seen = 0;
    for (int unsigned i = 1; i <= 3 * TMO && seen == 0; i++) begin
      @(negedge clk_in);
      bus.sd_byte_available = 1'b0;
      #1;
      if (timeout_err === 1'b1) seen = i;
    end
    n_chk++;
    if (seen < TMO || seen > TMO + 2) begin
      n_fail++;
      $display("FAIL timeout_latency: pulse after %0d idle cycles, expected %0d..%0d", seen, TMO, TMO + 2);
    end
    n_chk++;
    if (busy !== 1'b1 || bus.sd_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_state: busy=%b sd_rd=%b expected busy=1 sd_rd=0", busy, bus.sd_rd);
    end
    @(negedge clk_in);
    bus.sd_byte_available = 1'b1; bus.sd_dout = 8'($urandom);
    #1;
    n_chk++;
    if (timeout_err !== 1'b0 || busy !== 1'b1 ||
        {bus.req1_byte_available, bus.req0_byte_available} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_pulse_width: tmo=%b busy=%b avail=%b expected tmo=0 busy=1 avail=00",
               timeout_err, busy, {bus.req1_byte_available, bus.req0_byte_available});
    end
    do_drain();
    do_grant(1'b1, 1'b1, $urandom, $urandom, w);
    do_bytes(w, BB);
    do_drain();
  endtask

  task automatic test_withdraw();
    apply_reset();
    bus.sd_ready = 1'b0; bus.req1_read = 1'b1; bus.req1_addr = $urandom;
    for (int unsigned c = 0; c < 6; c++) begin
      if (c == 3) begin
        bus.req1_read = 1'b0; bus.sd_ready = 1'b1;
      end
      @(negedge clk_in); #1;
      n_chk++;
      if ({bus.req1_accepted, bus.req0_accepted, bus.sd_rd, busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL withdraw[%0d]: acc1,acc0,rd,busy=%b expected 0000", c,
                 {bus.req1_accepted, bus.req0_accepted, bus.sd_rd, busy});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic w;
    apply_reset();
    do_grant(1'b0, 1'b1, 32'h0, $urandom, w);
    do_bytes(w, 200);
    @(negedge clk_in);
    reset_in = 1'b1; bus.sd_byte_available = 1'b1; bus.sd_dout = 8'h5A;
    m_last = 1'b1;
    #1;
    n_chk++;
    if ({bus.sd_rd, bus.req0_accepted, bus.req1_accepted, busy, owner, timeout_err,
         bus.req0_byte_available, bus.req1_byte_available} !== 8'h00 ||
        bus.sd_address !== 32'h0 || bus.req0_dout !== 8'h00 || bus.req1_dout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: flags=%b addr=%h dout0=%h dout1=%h expected all 0",
               {bus.sd_rd, bus.req0_accepted, bus.req1_accepted, busy, owner, timeout_err,
                bus.req0_byte_available, bus.req1_byte_available},
               bus.sd_address, bus.req0_dout, bus.req1_dout);
    end
    @(negedge clk_in);
    reset_in = 1'b0;
    repeat (3) begin
      @(negedge clk_in);
      bus.sd_byte_available = 1'b1; bus.sd_dout = 8'($urandom);
      #1;
      n_chk++;
      if ({bus.req1_byte_available, bus.req0_byte_available, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_residual_bytes: avail1,avail0,busy=%b expected 000",
                 {bus.req1_byte_available, bus.req0_byte_available, busy});
      end
    end
    do_grant(1'b1, 1'b1, $urandom, $urandom, w);
    do_bytes(w, BB);
    do_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_withdraw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
